// File: rtl/updown_mod_counter_pkg.sv
// Shared definitions for the up/down modulo counter family.
//   CNT_MODE_WRAP / CNT_MODE_SAT : encodings of the sat_mode input
//   cnt_op_e                     : per-edge operation after priority decode
package counter_pkg;

  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } cnt_op_e;

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of updown_mod_counter.
//   master : drives clear, load, load_val, enable, up, sat_mode;
//            observes count, at_max, at_zero, wrap_pulse, sat_hit, load_err
//   slave  : the counter side (directions reversed)
interface updown_mod_counter_if #(
  parameter int unsigned WIDTH = 8
);

  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             up;
  logic             sat_mode;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_zero;
  logic             wrap_pulse;
  logic             sat_hit;
  logic             load_err;

  modport master (
    output clear, load, load_val, enable, up, sat_mode,
    input  count, at_max, at_zero, wrap_pulse, sat_hit, load_err
  );

  modport slave (
    input  clear, load, load_val, enable, up, sat_mode,
    output count, at_max, at_zero, wrap_pulse, sat_hit, load_err
  );

endinterface

// File: rtl/updown_mod_counter_next_calc.sv
// cnt_next_calc: combinational next-state logic of the modulo counter.
//   count, op, load_val, sat_mode in -> next_count, wrap, sat, clamp out.
//   wrap  : this op steps across a boundary in wrap mode
//   sat   : this op tries to step past a boundary in saturate mode
//   clamp : a load value above MAX_V was replaced by MAX_V
module cnt_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_V = '1
) (
  input  logic [WIDTH-1:0] count,
  input  cnt_op_e          op,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap,
  output logic             sat,
  output logic             clamp
);

  always_comb begin
    next_count = count;
    wrap       = 1'b0;
    sat        = 1'b0;
    clamp      = 1'b0;
    case (op)
      OP_CLEAR: next_count = '0;
      OP_LOAD: begin
        if (load_val > MAX_V) begin
          next_count = MAX_V;
          clamp      = 1'b1;
        end else begin
          next_count = load_val;
        end
      end
      OP_INC: begin
        // Boundary is tested before the add, so the WIDTH-bit sum never overflows.
        if (count == MAX_V) begin
          if (sat_mode == CNT_MODE_SAT) begin
            sat = 1'b1;
          end else begin
            next_count = '0;
            wrap       = 1'b1;
          end
        end else begin
          next_count = count + 1'b1;
        end
      end
      OP_DEC: begin
        if (count == '0) begin
          if (sat_mode == CNT_MODE_SAT) begin
            sat = 1'b1;
          end else begin
            next_count = MAX_V;
            wrap       = 1'b1;
          end
        end else begin
          next_count = count - 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter (0..MAX_VAL).
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of updown_mod_counter_if (controls in, count/flags/pulses out)
// Per-edge priority is clear > load > enable. Pulses are registered and
// coincide with the cycle showing the post-event count; flags decode count.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter longint unsigned  MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic                clk,
  input  logic                reset_n,
  updown_mod_counter_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 63) begin : g_bad_width
    $fatal(1, "updown_mod_counter: WIDTH must be in 2..63");
  end
  if (MAX_VAL == 64'd0 || MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
    $fatal(1, "updown_mod_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];

  cnt_op_e          op;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] next_count;
  logic             wrap;
  logic             sat;
  logic             clamp;
  logic             wrap_q;
  logic             sat_q;
  logic             err_q;

  always_comb begin
    op = OP_HOLD;
    if (bus.clear) begin
      op = OP_CLEAR;
    end else if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.enable) begin
      op = bus.up ? OP_INC : OP_DEC;
    end
  end

  cnt_next_calc #(
    .WIDTH (WIDTH),
    .MAX_V (MAX_V)
  ) u_next (
    .count      (count_q),
    .op         (op),
    .load_val   (bus.load_val),
    .sat_mode   (bus.sat_mode),
    .next_count (next_count),
    .wrap       (wrap),
    .sat        (sat),
    .clamp      (clamp)
  );

  // Pulse registers load every edge, so they self-clear unless the event repeats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= next_count;
      wrap_q  <= wrap;
      sat_q   <= sat;
      err_q   <= clamp;
    end
  end

  assign bus.count      = count_q;
  assign bus.at_max     = (count_q == MAX_V);
  assign bus.at_zero    = (count_q == '0);
  assign bus.wrap_pulse = wrap_q;
  assign bus.sat_hit    = sat_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: one instance at WIDTH=4/MAX_VAL=9
// and one at the full-range default WIDTH=8/MAX_VAL=255.
module tb_updown_mod_counter;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  updown_mod_counter_if #(.WIDTH(4)) bus4 ();
  updown_mod_counter_if #(.WIDTH(8)) bus8 ();

  updown_mod_counter #(
    .WIDTH   (4),
    .MAX_VAL (9)
  ) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  updown_mod_counter #(
    .WIDTH (8)
  ) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input int cnt, input bit wp, input bit sh, input bit le);
    check({tag, ".count"},      bus4.count, cnt);
    check({tag, ".at_zero"},    bus4.at_zero, (cnt == 0));
    check({tag, ".at_max"},     bus4.at_max, (cnt == 9));
    check({tag, ".wrap_pulse"}, bus4.wrap_pulse, wp);
    check({tag, ".sat_hit"},    bus4.sat_hit, sh);
    check({tag, ".load_err"},   bus4.load_err, le);
  endtask

  task automatic ctl4(input bit c, input bit l, input int lv, input bit e, input bit u, input bit s);
    bus4.clear    = c;
    bus4.load     = l;
    bus4.load_val = 4'(lv);
    bus4.enable   = e;
    bus4.up       = u;
    bus4.sat_mode = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    ctl4(0, 0, 0, 0, 0, 0);
    bus8.clear = 0; bus8.load = 0; bus8.load_val = '0;
    bus8.enable = 0; bus8.up = 0; bus8.sat_mode = 0;

    repeat (2) step();
    check4("rst", 0, 0, 0, 0);
    reset_n = 1'b1;
    step();
    check4("idle", 0, 0, 0, 0);

    // 1. asynchronous reset mid-count at 5
    ctl4(0, 1, 4, 0, 0, 0); step();
    check4("t1.load4", 4, 0, 0, 0);
    ctl4(0, 0, 0, 1, 1, 0); step();
    check4("t1.cnt5", 5, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 check4("t1.async", 0, 0, 0, 0);
    ctl4(0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b1;
    step();
    check4("t1.after", 0, 0, 0, 0);

    // 2. up-wrap over 10 edges
    ctl4(0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check4($sformatf("t2.e%0d", i), i % 10, (i == 10), 0, 0);
    end

    // 3. down-saturate from 2
    ctl4(0, 1, 2, 0, 0, 1); step();
    check4("t3.load2", 2, 0, 0, 0);
    ctl4(0, 0, 0, 1, 0, 1);
    step(); check4("t3.e1", 1, 0, 0, 0);
    step(); check4("t3.e2", 0, 0, 0, 0);
    step(); check4("t3.e3", 0, 0, 1, 0);
    step(); check4("t3.e4", 0, 0, 1, 0);
    ctl4(0, 0, 0, 0, 0, 1); step();
    check4("t3.hold", 0, 0, 0, 0);

    // 4. load clamp and priority
    ctl4(0, 1, 12, 0, 0, 0); step();
    check4("t4.clamp", 9, 0, 0, 1);
    ctl4(0, 0, 0, 0, 0, 0); step();
    check4("t4.clamp_end", 9, 0, 0, 0);
    ctl4(1, 1, 3, 1, 1, 0); step();
    check4("t4.clr_prio", 0, 0, 0, 0);
    ctl4(0, 1, 7, 1, 1, 0); step();
    check4("t4.load_prio", 7, 0, 0, 0);
    ctl4(0, 1, 9, 0, 0, 0); step();
    check4("t4.load_max", 9, 0, 0, 0);
    ctl4(0, 0, 0, 1, 1, 1); step();
    check4("t4.sat_up", 9, 0, 1, 0);

    // 5. down-wrap then direction switch
    ctl4(1, 0, 0, 0, 0, 0); step();
    check4("t5.clr", 0, 0, 0, 0);
    ctl4(0, 0, 0, 1, 0, 0); step();
    check4("t5.dwrap", 9, 1, 0, 0);
    ctl4(0, 0, 0, 1, 1, 0); step();
    check4("t5.uwrap", 0, 1, 0, 0);
    ctl4(0, 0, 0, 0, 1, 0); step();
    check4("t5.hold", 0, 0, 0, 0);

    // 6. full-range default instance
    bus8.load = 1; bus8.load_val = 8'd254; step();
    check("t6.load", bus8.count, 254);
    bus8.load = 0; bus8.enable = 1; bus8.up = 1; step();
    check("t6.e1.count", bus8.count, 255);
    check("t6.e1.at_max", bus8.at_max, 1);
    check("t6.e1.wrap", bus8.wrap_pulse, 0);
    step();
    check("t6.e2.count", bus8.count, 0);
    check("t6.e2.at_zero", bus8.at_zero, 1);
    check("t6.e2.wrap", bus8.wrap_pulse, 1);
    bus8.enable = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
